// File: rtl/jk_bank_ctrl_if.sv
// Command and bank-observation bundle for jk_bank_ctrl.
// Master issues commands and watches the bank; slave is the controller.
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready.
    // The source keeps cmd_valid and its fields stable until that edge.
    // cmd_ready is high only while the controller is idle.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] j_bus;
    logic [WIDTH-1:0] k_bus;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [1:0]       dbg_state;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_count,
        input  cmd_ready, j_bus, k_bus, q, busy, done, wrap, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_count,
        output cmd_ready, j_bus, k_bus, q, busy, done, wrap, dbg_state
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving an internal WIDTH-bit JK flip-flop bank.
// Optional sticky count-wrap flag is built only when JK_BANK_WRAP_EN is defined.
module jk_bank_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           reset,
    jk_bank_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_CLR    = 3'b011;
    localparam logic [2:0] OP_TOG    = 3'b100;
    localparam logic [2:0] OP_CNT_UP = 3'b101;
    localparam logic [2:0] OP_CNT_DN = 3'b110;

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] arg_r;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] remaining;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;
    logic             accept;
    logic             cmd_is_count;
    logic             op_is_count;

    // Bit i toggles when every lower bit of v is 1 (ripple-carry toggle pattern).
    function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        logic             acc;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = acc;
            acc  = acc & v[i];
        end
        return m;
    endfunction

    assign accept       = bus.cmd_valid && ready_r;
    assign cmd_is_count = (bus.cmd_op == OP_CNT_UP) || (bus.cmd_op == OP_CNT_DN);
    assign op_is_count  = (op_r == OP_CNT_UP) || (op_r == OP_CNT_DN);

    always_comb begin
        j_c = '0;
        k_c = '0;
        if (state == EXEC) begin
            case (op_r)
                OP_LOAD:   begin j_c = arg_r;             k_c = ~arg_r;            end
                OP_SET:    begin j_c = arg_r;             k_c = '0;                end
                OP_CLR:    begin j_c = '0;                k_c = arg_r;             end
                OP_TOG:    begin j_c = arg_r;             k_c = arg_r;             end
                OP_CNT_UP: begin j_c = toggle_mask(q_r);  k_c = toggle_mask(q_r);  end
                OP_CNT_DN: begin j_c = toggle_mask(~q_r); k_c = toggle_mask(~q_r); end
                default:   begin j_c = '0;                k_c = '0;                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_r      <= OP_NOP;
            arg_r     <= '0;
            remaining <= '0;
            q_r       <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            // JK characteristic equation, applied to every bit on every edge.
            q_r <= (j_c & ~q_r) | (~k_c & q_r);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r      <= bus.cmd_op;
                        arg_r     <= bus.cmd_arg;
                        remaining <= bus.cmd_count;
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        if (cmd_is_count && (bus.cmd_count == '0)) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (!op_is_count || (remaining == CNT_W'(1))) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef JK_BANK_WRAP_EN
    logic wrap_r;
    logic wrap_step;

    // A step wraps when counting up from all-ones or down from zero.
    assign wrap_step = (state == EXEC) &&
                       (((op_r == OP_CNT_UP) && (&q_r)) ||
                        ((op_r == OP_CNT_DN) && (q_r == '0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_r <= 1'b0;
        end else if (accept) begin
            wrap_r <= 1'b0;
        end else if (wrap_step) begin
            wrap_r <= 1'b1;
        end
    end

    assign bus.wrap = wrap_r;
`else
    assign bus.wrap = 1'b0;
`endif

    assign bus.cmd_ready = ready_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.q         = q_r;
    assign bus.j_bus     = j_c;
    assign bus.k_bus     = k_c;
    assign bus.dbg_state = state;
endmodule
